// File: rtl/ppu_frame_sync.sv
// ppu_frame_sync: publishes CPU-side PPU control registers during vblank.
// Commits only while the CPU has no update in flight; reports commit/skip.
module ppu_frame_sync #(
    parameter int          SKIP_CNT_W  = 8,
    parameter int          FRAME_CNT_W = 16,
    parameter logic [2:0]  RST_ENABLE  = 3'b000,
    parameter logic [23:0] RST_BGCOLOR = 24'h000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   vblank_start,
    input  logic                   vblank_end_soon,
    input  logic                   cpu_wr_busy,
    input  logic [31:0]            cpu_bgscroll,
    input  logic [31:0]            cpu_fgscroll,
    input  logic [2:0]             cpu_enable,
    input  logic [23:0]            cpu_bgcolor,
    output logic [31:0]            act_bgscroll,
    output logic [31:0]            act_fgscroll,
    output logic [2:0]             act_enable,
    output logic [23:0]            act_bgcolor,
    output logic                   commit_pulse,
    output logic                   skip_pulse,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic [SKIP_CNT_W-1:0]  skip_cnt,
    output logic                   in_vblank
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DEFER = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_n;
    logic   do_commit;
    logic   do_skip;

    // Next state plus commit/skip decisions for this cycle.
    // A vblank_start always wins over a coincident vblank_end_soon.
    always_comb begin
        state_n   = state;
        do_commit = 1'b0;
        do_skip   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (vblank_start) begin
                    if (!cpu_wr_busy) begin
                        do_commit = 1'b1;
                        state_n   = S_DONE;
                    end else begin
                        state_n = S_DEFER;
                    end
                end
            end
            S_DEFER: begin
                if (vblank_start) begin
                    // Previous vblank closed without a commit.
                    do_skip = 1'b1;
                    if (!cpu_wr_busy) begin
                        do_commit = 1'b1;
                        state_n   = S_DONE;
                    end else begin
                        state_n = S_DEFER;
                    end
                end else if (vblank_end_soon) begin
                    do_skip = 1'b1;
                    state_n = S_IDLE;
                end else if (!cpu_wr_busy) begin
                    do_commit = 1'b1;
                    state_n   = S_DONE;
                end
            end
            S_DONE: begin
                if (vblank_start) begin
                    if (!cpu_wr_busy) begin
                        do_commit = 1'b1;
                        state_n   = S_DONE;
                    end else begin
                        state_n = S_DEFER;
                    end
                end else if (vblank_end_soon) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Active register set, loaded from the CPU copy on commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_bgscroll <= '0;
            act_fgscroll <= '0;
            act_enable   <= RST_ENABLE;
            act_bgcolor  <= RST_BGCOLOR;
        end else if (do_commit) begin
            act_bgscroll <= cpu_bgscroll;
            act_fgscroll <= cpu_fgscroll;
            act_enable   <= cpu_enable;
            act_bgcolor  <= cpu_bgcolor;
        end
    end

    // Status pulses; a skip that restarts straight into a commit is
    // still counted, but only the commit is signalled so the two
    // pulses stay mutually exclusive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_pulse <= 1'b0;
            skip_pulse   <= 1'b0;
            in_vblank    <= 1'b0;
        end else begin
            commit_pulse <= do_commit;
            skip_pulse   <= do_skip & ~do_commit;
            in_vblank    <= (state_n != S_IDLE);
        end
    end

    // Wrapping commit counter and saturating skip counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            skip_cnt  <= '0;
        end else begin
            if (do_commit) begin
                frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            end
            if (do_skip && (skip_cnt != '1)) begin
                skip_cnt <= skip_cnt + SKIP_CNT_W'(1);
            end
        end
    end

endmodule
